// File: rtl/exc_sequencer_if.sv
// Purpose: groups the exception-sequencer signals exchanged with the M stage,
//   cp0 and the PC/NPC select logic into one bundle.
// Signals:
//   From pipeline/cp0 (inputs to the sequencer):
//     HWIntRaw[5:0]   raw device interrupt lines [7:2] (asynchronous)
//     ExcReq_M        M-stage instruction carries an exception
//     ExcCode_M[4:0]  its cause code
//     eret_M          M-stage instruction is ERET
//     stall           pipeline paused, M stage not committing
//     IntReq          cp0 says an exception or enabled interrupt is taken
//     EPC[31:0]       cp0 EPC value
//   From the sequencer (outputs):
//     HWInt[5:0]      synchronised interrupt lines to cp0
//     Exc, ExcCode    exception commit and cause code to cp0
//     EXLClr          clear SR.EXL on ERET commit
//     Flush           kill F/D/E/M stage contents
//     Redirect        force NPC = NPC_Out this cycle
//     NPC_Out[31:0]   redirect target (0 when Redirect is low)
//     Busy            sequencer is not idle
//     EntryCnt        saturating count of taken entries
//     state_dbg[1:0]  raw FSM state for observation
// Handshake: there is no valid/ready pair here. IntReq is a level request that
//   is acted on only in a cycle where the sequencer is idle and stall is low;
//   in any other cycle it is ignored and must be re-presented by cp0.
interface exc_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic [5:0]       HWIntRaw;
    logic             ExcReq_M;
    logic [4:0]       ExcCode_M;
    logic             eret_M;
    logic             stall;
    logic             IntReq;
    logic [31:0]      EPC;

    logic [5:0]       HWInt;
    logic             Exc;
    logic [4:0]       ExcCode;
    logic             EXLClr;
    logic             Flush;
    logic             Redirect;
    logic [31:0]      NPC_Out;
    logic             Busy;
    logic [CNT_W-1:0] EntryCnt;
    logic [1:0]       state_dbg;

    modport master (
        output HWIntRaw, ExcReq_M, ExcCode_M, eret_M, stall, IntReq, EPC,
        input  HWInt, Exc, ExcCode, EXLClr, Flush, Redirect, NPC_Out, Busy,
               EntryCnt, state_dbg
    );

    modport slave (
        input  HWIntRaw, ExcReq_M, ExcCode_M, eret_M, stall, IntReq, EPC,
        output HWInt, Exc, ExcCode, EXLClr, Flush, Redirect, NPC_Out, Busy,
               EntryCnt, state_dbg
    );
endinterface

// File: rtl/exc_sequencer.sv
// Purpose: sequences exception/interrupt entry and ERET return around cp0.
//   Synchronises raw interrupt lines into HWInt, gates M-stage exception
//   requests into Exc, and after cp0 raises IntReq drives pipeline flush and
//   an NPC redirect to the handler (or to EPC for ERET).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    exc_sequencer_if.slave (see interface file for the signal list)
// Parameters:
//   HANDLER_PC    handler entry address
//   FLUSH_CYCLES  cycles Flush is held after an entry (1..7)
//   CNT_W         width of the saturating entry counter
module exc_sequencer #(
    parameter logic [31:0] HANDLER_PC   = 32'h0000_4180,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic           clk,
    input  logic           reset,
    exc_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_RET   = 2'd2;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             first_q, first_d;
    logic [31:0]      ret_pc_q, ret_pc_d;
    logic [CNT_W-1:0] entry_cnt_q, entry_cnt_d;
    logic [5:0]       sync1_q, sync2_q;

    logic idle;
    logic take_int;
    logic take_ret;
    logic redirect_handler;

    assign idle     = (state_q == S_IDLE);
    // IntReq wins over ERET when both arrive in the same idle cycle.
    assign take_int = idle & bus.IntReq & ~bus.stall;
    assign take_ret = idle & bus.eret_M & ~bus.stall & ~bus.IntReq;

    assign redirect_handler = (state_q == S_FLUSH) & first_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        ret_pc_d    = ret_pc_q;
        entry_cnt_d = entry_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (take_int) begin
                    state_d = S_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                    first_d = 1'b1;
                    if (entry_cnt_q != {CNT_W{1'b1}}) begin
                        entry_cnt_d = entry_cnt_q + CNT_ONE;
                    end
                end else if (take_ret) begin
                    state_d  = S_RET;
                    ret_pc_d = bus.EPC;
                end
            end
            S_FLUSH: begin
                first_d = 1'b0;
                // Counter starts at FLUSH_CYCLES-1, so leaving on zero gives
                // exactly FLUSH_CYCLES cycles in this state.
                if (cnt_q == 3'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RET: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            first_q     <= 1'b0;
            ret_pc_q    <= 32'd0;
            entry_cnt_q <= {CNT_W{1'b0}};
            sync1_q     <= 6'd0;
            sync2_q     <= 6'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            ret_pc_q    <= ret_pc_d;
            entry_cnt_q <= entry_cnt_d;
            sync1_q     <= bus.HWIntRaw;
            sync2_q     <= sync1_q;
        end
    end

    // Exc deliberately ignores IntReq: cp0 derives IntReq from Exc, so
    // looking at it here would close a combinational loop.
    assign bus.Exc       = idle & bus.ExcReq_M & ~bus.stall;
    assign bus.ExcCode   = bus.ExcCode_M;
    assign bus.EXLClr    = take_ret;
    assign bus.HWInt     = sync2_q;
    // Flush/Redirect decode straight from state so an asynchronous reset
    // drops them immediately.
    assign bus.Flush     = ~idle;
    assign bus.Redirect  = redirect_handler | (state_q == S_RET);
    assign bus.NPC_Out   = (state_q == S_RET) ? ret_pc_q :
                           redirect_handler   ? HANDLER_PC : 32'd0;
    assign bus.Busy      = ~idle;
    assign bus.EntryCnt  = entry_cnt_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_exc_sequencer.sv
module tb_exc_sequencer;
  localparam logic [31:0] HANDLER = 32'h0000_4180;
  localparam int          FC      = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exc_sequencer_if #(.CNT_W(16)) bus ();
  exc_sequencer #(.HANDLER_PC(HANDLER), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // narrow-counter instance so saturation is reachable in a few cycles
  exc_sequencer_if #(.CNT_W(4)) sbus ();
  exc_sequencer #(.HANDLER_PC(32'h0000_0080), .FLUSH_CYCLES(1), .CNT_W(4)) sat_dut (
    .clk(clk), .reset(reset), .bus(sbus)
  );

  // scoreboard: each queued beat is one expected busy cycle {redirect, npc}
  logic [32:0] exp_q[$];
  logic [5:0]  hist_q[$];
  logic [15:0] exp_cnt;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    hist_q.delete();
    hist_q.push_back(6'd0);
    hist_q.push_back(6'd0);
    exp_cnt = 16'd0;
  endtask

  task automatic set_in(input logic [5:0] raw, input logic exc, input logic [4:0] code,
                        input logic eret, input logic stl, input logic ireq,
                        input logic [31:0] epc);
    bus.HWIntRaw  = raw;
    bus.ExcReq_M  = exc;
    bus.ExcCode_M = code;
    bus.eret_M    = eret;
    bus.stall     = stl;
    bus.IntReq    = ireq;
    bus.EPC       = epc;
  endtask

  task automatic check_outputs();
    logic        busy;
    logic [32:0] beat;
    busy = (exp_q.size() != 0);
    beat = busy ? exp_q[0] : 33'd0;
    check("HWInt",    32'(bus.HWInt),    32'(hist_q[0]));
    check("Busy",     32'(bus.Busy),     32'(busy));
    check("Flush",    32'(bus.Flush),    32'(busy));
    check("Redirect", 32'(bus.Redirect), 32'(beat[32]));
    check("NPC_Out",  bus.NPC_Out,       beat[31:0]);
    check("Exc",      32'(bus.Exc),      32'(!busy && bus.ExcReq_M && !bus.stall));
    check("ExcCode",  32'(bus.ExcCode),  32'(bus.ExcCode_M));
    check("EXLClr",   32'(bus.EXLClr),   32'(!busy && bus.eret_M && !bus.stall && !bus.IntReq));
    check("EntryCnt", 32'(bus.EntryCnt), 32'(exp_cnt));
  endtask

  // advance the reference by one rising edge using the inputs held this cycle
  task automatic model_edge();
    hist_q.push_back(bus.HWIntRaw);
    void'(hist_q.pop_front());
    if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end else if (bus.IntReq && !bus.stall) begin
      exp_q.push_back({1'b1, HANDLER});
      for (int i = 1; i < FC; i++) exp_q.push_back(33'd0);
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end else if (bus.eret_M && !bus.stall) begin
      exp_q.push_back({1'b1, bus.EPC});
    end
  endtask

  // called at a negedge with inputs already set
  task automatic tick();
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_in();
    set_in(6'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    sbus.HWIntRaw = 6'd0; sbus.ExcReq_M = 1'b0; sbus.ExcCode_M = 5'd0;
    sbus.eret_M = 1'b0; sbus.stall = 1'b0; sbus.IntReq = 1'b0; sbus.EPC = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_outputs();
    reset = 1'b0;
    @(negedge clk);

    // interrupt line reaches HWInt two edges later
    set_in(6'b000001, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (3) tick();

    // exception entry: Exc in request cycle, then 2 flush cycles to handler
    set_in(6'd0, 1'b1, 5'd12, 1'b0, 1'b0, 1'b1, 32'd0);
    tick();
    idle_in();
    repeat (3) tick();

    // ERET: EXLClr now, then one redirect cycle to EPC
    set_in(6'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0000_3010);
    tick();
    idle_in();
    repeat (2) tick();

    // ERET and IntReq together: handler path, no EXLClr
    set_in(6'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 32'h0000_3010);
    tick();
    idle_in();
    repeat (3) tick();

    // stalled exception held for 3 cycles, then commits
    set_in(6'd0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b1, 32'd0);
    repeat (3) tick();
    set_in(6'd0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    idle_in();
    tick();

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      set_in(6'($urandom), ($urandom_range(0, 2) == 0), 5'($urandom),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
      tick();
    end
    idle_in();
    repeat (4) tick();

    // asynchronous reset in the middle of a flush
    set_in(6'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd0);
    tick();
    idle_in();
    check("MidFlushBusy", 32'(bus.Busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("RstFlush",    32'(bus.Flush),    32'd0);
    check("RstRedirect", 32'(bus.Redirect), 32'd0);
    check("RstNPC",      bus.NPC_Out,       32'd0);
    check("RstBusy",     32'(bus.Busy),     32'd0);
    check("RstEntryCnt", 32'(bus.EntryCnt), 32'd0);
    #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    repeat (3) tick();

    // saturation on the narrow counter: one entry every two edges
    sbus.IntReq = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(posedge clk);
      #1;
      check("SatCnt",  32'(sbus.EntryCnt), 32'((k > 15) ? 15 : k));
      check("SatBusy", 32'(sbus.Busy),     32'd0);
    end
    sbus.IntReq = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
